// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the switch host transmitter
package eth_pkg;

    typedef logic [31:0] word_t;

    // Header words ahead of the payload: DA then SA
    localparam int HDR_WORDS = 2;

    // Switch ingress FIFO word layout: {data[31:0], start, end}
    localparam int FIFO_W         = 34;
    localparam int FIFO_DATA_MSB  = 33;
    localparam int FIFO_DATA_LSB  = 2;
    localparam int FIFO_START_BIT = 1;
    localparam int FIFO_END_BIT   = 0;

    // Depth of the switch ingress FIFO; a whole packet must fit in it
    localparam int SW_FIFO_DEPTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        DA,
        SA,
        PAY,
        CHK,
        GAP
    } tx_state_t;

    function automatic logic [FIFO_W-1:0] fifo_pack(input word_t data, input logic start, input logic last);
        return {data, start, last};
    endfunction

endpackage

// File: rtl/eth_pkt_tx_if.sv
// rtl/eth_pkt_tx_if.sv - descriptor handshake and switch port framing bundle
interface eth_pkt_tx_if #(
    parameter int LEN_W = 8
);
    import eth_pkg::*;

    // Descriptor handshake
    logic             req_valid;
    logic             req_ready;
    word_t            req_da;
    word_t            req_sa;
    logic [LEN_W-1:0] req_len;
    word_t            req_seed;

    // Switch port framing and backpressure
    logic             port_stall;
    word_t            o_data;
    logic             o_start;
    logic             o_end;

    // Host / switch side: issues descriptors, applies stall, observes words
    modport master (
        output req_valid, req_da, req_sa, req_len, req_seed, port_stall,
        input  req_ready, o_data, o_start, o_end
    );

    // Transmitter side
    modport slave (
        input  req_valid, req_da, req_sa, req_len, req_seed, port_stall,
        output req_ready, o_data, o_start, o_end
    );

endinterface

// File: rtl/eth_xor_acc.sv
// rtl/eth_xor_acc.sv - clear-on-start XOR checksum accumulator for outgoing words
module eth_xor_acc
    import eth_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  i_start,
    input  logic  i_en,
    input  word_t i_data,
    output word_t o_sum
);

    word_t r_acc;

    // Start word reseeds the running XOR; later words fold into it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else if (i_start) begin
            r_acc <= i_data;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    // Sum including the word currently on the port
    assign o_sum = i_start ? i_data : (r_acc ^ i_data);

endmodule

// File: rtl/eth_pkt_tx.sv
// rtl/eth_pkt_tx.sv - packet transmitter for one switch ingress port (optional ETH_PKT_TX_CHKSUM_EN)
module eth_pkt_tx
    import eth_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 28,
    parameter int IPG     = 2
) (
    input  logic         clk,
    input  logic         rstn,
    eth_pkt_tx_if.slave  bus,
    output logic         busy,
    output logic [15:0]  pkt_count
);

    localparam int                GAP_W      = (IPG > 1) ? $clog2(IPG) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((IPG > 0) ? IPG - 1 : 0);
    localparam logic [LEN_W-1:0]  W_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam tx_state_t         POST_STATE = (IPG == 0) ? IDLE : GAP;
`ifdef ETH_PKT_TX_CHKSUM_EN
    localparam bit                CHK_EN     = 1'b1;
`else
    localparam bit                CHK_EN     = 1'b0;
`endif

    // Packets are sent without honouring stall, so the largest one must fit the switch FIFO
    if (HDR_WORDS + MAX_LEN + 1 > SW_FIFO_DEPTH) begin : g_fifo_check
        $error("eth_pkt_tx: MAX_LEN too large for switch FIFO depth");
    end

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    word_t            r_data;
    word_t            w_data_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic             r_end;
    logic             w_end_nxt;
    logic             r_busy;
    logic [15:0]      r_pkt_count;
    word_t            r_sa;
    word_t            w_sa_nxt;
    word_t            r_pay;
    word_t            w_pay_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_clamped;

    assign bus.req_ready = rstn && (r_state == IDLE) && !bus.port_stall;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_len_clamped = (bus.req_len > W_MAX_LEN) ? W_MAX_LEN : bus.req_len;

`ifdef ETH_PKT_TX_CHKSUM_EN
    word_t w_sum;

    eth_xor_acc u_xor_acc (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (r_start),
        .i_en    ((r_state == SA) || (r_state == PAY)),
        .i_data  (r_data),
        .o_sum   (w_sum)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the port word to present while in that next state
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = '0;
        w_start_nxt = 1'b0;
        w_end_nxt   = 1'b0;
        w_sa_nxt    = r_sa;
        w_pay_nxt   = r_pay;
        w_rem_nxt   = r_rem;
        w_gap_nxt   = r_gap;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = DA;
                    w_data_nxt  = bus.req_da;
                    w_start_nxt = 1'b1;
                    w_sa_nxt    = bus.req_sa;
                    w_pay_nxt   = bus.req_seed;
                    w_rem_nxt   = w_len_clamped;
                end
            end
            DA: begin
                w_state_nxt = SA;
                w_data_nxt  = r_sa;
                w_end_nxt   = (r_rem == '0) && !CHK_EN;
            end
            SA, PAY: begin
                if (r_rem != '0) begin
                    w_state_nxt = PAY;
                    w_data_nxt  = r_pay;
                    w_pay_nxt   = r_pay + 32'd1;
                    w_rem_nxt   = r_rem - 1'b1;
                    w_end_nxt   = (r_rem == LEN_W'(1)) && !CHK_EN;
                end else begin
`ifdef ETH_PKT_TX_CHKSUM_EN
                    w_state_nxt = CHK;
                    w_data_nxt  = w_sum;
                    w_end_nxt   = 1'b1;
`else
                    w_state_nxt = POST_STATE;
                    w_gap_nxt   = '0;
`endif
                end
            end
            CHK: begin
                w_state_nxt = POST_STATE;
                w_gap_nxt   = '0;
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered port outputs, descriptor latches and counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data      <= '0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_count <= '0;
            r_sa        <= '0;
            r_pay       <= '0;
            r_rem       <= '0;
            r_gap       <= '0;
        end else begin
            r_data      <= w_data_nxt;
            r_start     <= w_start_nxt;
            r_end       <= w_end_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_pkt_count <= r_pkt_count + 16'(w_end_nxt);
            r_sa        <= w_sa_nxt;
            r_pay       <= w_pay_nxt;
            r_rem       <= w_rem_nxt;
            r_gap       <= w_gap_nxt;
        end
    end

    assign bus.o_data  = r_data;
    assign bus.o_start = r_start;
    assign bus.o_end   = r_end;
    assign busy        = r_busy;
    assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_eth_pkt_tx.sv
// tb/tb_eth_pkt_tx.sv - directed self-checking bench for eth_pkt_tx
module tb_eth_pkt_tx;
    import eth_pkg::*;

    localparam int MAXL = 28;
`ifdef ETH_PKT_TX_CHKSUM_EN
    localparam int CHKW = 1;
`else
    localparam int CHKW = 0;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        busy, busy0;
    logic [15:0] pkt_count, pkt_count0;
    int          checks = 0;
    int          errors = 0;

    word_t got_data [64];
    logic  got_s    [64];
    logic  got_e    [64];
    int    got_n;
    bit    got_to;

    eth_pkt_tx_if #(.LEN_W(8)) bus ();
    eth_pkt_tx_if #(.LEN_W(8)) bus0 ();

    eth_pkt_tx #(.LEN_W(8), .MAX_LEN(28), .IPG(2)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .pkt_count(pkt_count)
    );

    eth_pkt_tx #(.LEN_W(8), .MAX_LEN(28), .IPG(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0), .busy(busy0), .pkt_count(pkt_count0)
    );

    always #5 clk = ~clk;

    function automatic int pay_n(input logic [7:0] len);
        return (len > 8'(MAXL)) ? MAXL : int'(len);
    endfunction

    // Expected k-th word of a packet: DA, SA, seed+i payload, then XOR of all
    function automatic word_t exp_word(input int k, input word_t da, input word_t sa, input word_t seed, input int n);
        word_t x;
        if (k == 0) return da;
        if (k == 1) return sa;
        if (k < 2 + n) return seed + word_t'(k - 2);
        x = da ^ sa;
        for (int i = 0; i < n; i++) x = x ^ (seed + word_t'(i));
        return x;
    endfunction

    // Offer a descriptor on the IPG=2 instance and capture words until o_end
    task automatic send_pkt(input word_t da, input word_t sa, input logic [7:0] len, input word_t seed);
        int cyc;
        got_n  = 0;
        got_to = 1'b0;
        @(negedge clk);
        bus.req_da = da; bus.req_sa = sa; bus.req_len = len; bus.req_seed = seed;
        bus.req_valid = 1'b1;
        cyc = 0;
        while (!bus.req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.req_ready) begin
            got_to = 1'b1;
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_da = ~da; bus.req_sa = ~sa; bus.req_len = 8'd7; bus.req_seed = ~seed;
        cyc = 0;
        while (cyc < 40) begin
            got_data[got_n] = bus.o_data;
            got_s[got_n]    = bus.o_start;
            got_e[got_n]    = bus.o_end;
            got_n++;
            if (bus.o_end) break;
            @(negedge clk);
            cyc++;
        end
        if (!got_e[got_n-1]) got_to = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.port_stall = 1'b0;
        bus.req_da = '0; bus.req_sa = '0; bus.req_len = '0; bus.req_seed = '0;
        bus0.req_valid = 1'b0; bus0.port_stall = 1'b0;
        bus0.req_da = '0; bus0.req_sa = '0; bus0.req_len = '0; bus0.req_seed = '0;
        rstn = 1'b0;
        #12;
        checks++;
        if (bus.o_data !== 32'h0 || bus.o_start !== 1'b0 || bus.o_end !== 1'b0)
            begin errors++; $display("FAIL reset_port got data=%h s=%b e=%b exp 0 0 0", bus.o_data, bus.o_start, bus.o_end); end
        checks++;
        if (busy !== 1'b0 || pkt_count !== 16'd0)
            begin errors++; $display("FAIL reset_status got busy=%b cnt=%0d exp 0 0", busy, pkt_count); end
        checks++;
        if (bus.req_ready !== 1'b0)
            begin errors++; $display("FAIL reset_ready got %b exp 0", bus.req_ready); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_basic();
        int n, nexp;
        send_pkt(32'hAAAA0001, 32'hBBBB0002, 8'd3, 32'h10);
        n = pay_n(8'd3); nexp = 2 + n + CHKW;
        checks++;
        if (got_to || got_n != nexp)
            begin errors++; $display("FAIL basic_len got %0d timeout=%0b exp %0d", got_n, got_to, nexp); end
        for (int k = 0; k < got_n && k < nexp; k++) begin
            checks++;
            if (got_data[k] !== exp_word(k, 32'hAAAA0001, 32'hBBBB0002, 32'h10, n) || got_s[k] !== (k == 0) || got_e[k] !== (k == nexp - 1))
                begin errors++; $display("FAIL basic_word[%0d] got %h s=%b e=%b exp %h", k, got_data[k], got_s[k], got_e[k], exp_word(k, 32'hAAAA0001, 32'hBBBB0002, 32'h10, n)); end
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || bus.o_data !== 32'h0 || bus.o_start !== 1'b0 || bus.o_end !== 1'b0 || bus.req_ready !== 1'b0)
                begin errors++; $display("FAIL basic_gap[%0d] got busy=%b data=%h ready=%b exp 1 0 0", g, busy, bus.o_data, bus.req_ready); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL basic_idle got busy=%b ready=%b exp 0 1", busy, bus.req_ready); end
        checks++;
        if (pkt_count !== 16'd1)
            begin errors++; $display("FAIL basic_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_zero_len();
        int nexp;
        send_pkt(32'h12345678, 32'h0F0F0F0F, 8'd0, 32'hDEAD0000);
        nexp = 2 + CHKW;
        checks++;
        if (got_to || got_n != nexp)
            begin errors++; $display("FAIL zero_len got %0d timeout=%0b exp %0d", got_n, got_to, nexp); end
        for (int k = 0; k < got_n && k < nexp; k++) begin
            checks++;
            if (got_data[k] !== exp_word(k, 32'h12345678, 32'h0F0F0F0F, 32'hDEAD0000, 0) || got_s[k] !== (k == 0) || got_e[k] !== (k == nexp - 1))
                begin errors++; $display("FAIL zero_word[%0d] got %h s=%b e=%b exp %h", k, got_data[k], got_s[k], got_e[k], exp_word(k, 32'h12345678, 32'h0F0F0F0F, 32'hDEAD0000, 0)); end
        end
        checks++;
        if (pkt_count !== 16'd2)
            begin errors++; $display("FAIL zero_count got %0d exp 2", pkt_count); end
    endtask

    task automatic test_stall();
        int cyc, k, nexp;
        @(negedge clk);
        bus.port_stall = 1'b1;
        bus.req_da = 32'hC0DE0001; bus.req_sa = 32'hC0DE0002; bus.req_len = 8'd4; bus.req_seed = 32'h100;
        bus.req_valid = 1'b1;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.req_ready !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL stall_hold[%0d] got ready=%b busy=%b exp 0 0", i, bus.req_ready, busy); end
            @(negedge clk);
        end
        bus.port_stall = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL stall_release got ready=%b exp 1", bus.req_ready); end
        @(negedge clk);
        checks++;
        if (bus.o_data !== 32'hC0DE0001 || bus.o_start !== 1'b1)
            begin errors++; $display("FAIL stall_first got %h s=%b exp c0de0001 1", bus.o_data, bus.o_start); end
        bus.req_valid = 1'b0;
        bus.port_stall = 1'b1;
        nexp = 2 + 4 + CHKW;
        k = 0;
        while (k < 40 && bus.o_end !== 1'b1) begin
            @(negedge clk);
            k++;
            checks++;
            if (bus.o_data !== exp_word(k, 32'hC0DE0001, 32'hC0DE0002, 32'h100, 4) || bus.o_start !== 1'b0)
                begin errors++; $display("FAIL stall_word[%0d] got %h s=%b exp %h", k, bus.o_data, bus.o_start, exp_word(k, 32'hC0DE0001, 32'hC0DE0002, 32'h100, 4)); end
        end
        checks++;
        if (k + 1 != nexp)
            begin errors++; $display("FAIL stall_len got %0d exp %0d", k + 1, nexp); end
        bus.port_stall = 1'b0;
        checks++;
        if (pkt_count !== 16'd3)
            begin errors++; $display("FAIL stall_count got %0d exp 3", pkt_count); end
    endtask

    task automatic test_clamp();
        int nexp;
        send_pkt(32'h11110000, 32'h22220000, 8'd200, 32'hFFFFFFFE);
        nexp = 2 + MAXL + CHKW;
        checks++;
        if (got_to || got_n != nexp)
            begin errors++; $display("FAIL clamp_len got %0d timeout=%0b exp %0d", got_n, got_to, nexp); end
        for (int k = 0; k < got_n && k < nexp; k++) begin
            checks++;
            if (got_data[k] !== exp_word(k, 32'h11110000, 32'h22220000, 32'hFFFFFFFE, MAXL) || got_s[k] !== (k == 0) || got_e[k] !== (k == nexp - 1))
                begin errors++; $display("FAIL clamp_word[%0d] got %h s=%b e=%b exp %h", k, got_data[k], got_s[k], got_e[k], exp_word(k, 32'h11110000, 32'h22220000, 32'hFFFFFFFE, MAXL)); end
        end
        checks++;
        if (got_data[4] !== 32'h0 || got_data[29] !== 32'h19)
            begin errors++; $display("FAIL clamp_wrap got %h %h exp 00000000 00000019", got_data[4], got_data[29]); end
        checks++;
        if (pkt_count !== 16'd4)
            begin errors++; $display("FAIL clamp_count got %0d exp 4", pkt_count); end
    endtask

    task automatic test_back_to_back();
        localparam int PER = 3 + CHKW + 1;
        int    k;
        word_t ew;
        logic  es, ee, eb;
        @(negedge clk);
        bus0.req_da = 32'h0B0B0001; bus0.req_sa = 32'h0B0B0002; bus0.req_len = 8'd1; bus0.req_seed = 32'h55;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        for (int idx = 0; idx < 3 * PER; idx++) begin
            k  = idx % PER;
            ew = (k < PER - 1) ? exp_word(k, 32'h0B0B0001, 32'h0B0B0002, 32'h55, 1) : 32'h0;
            es = (k == 0);
            ee = (k == PER - 2);
            eb = (k < PER - 1);
            checks++;
            if (bus0.o_data !== ew || bus0.o_start !== es || bus0.o_end !== ee || busy0 !== eb)
                begin errors++; $display("FAIL b2b_cycle[%0d] got %h s=%b e=%b busy=%b exp %h %b %b %b", idx, bus0.o_data, bus0.o_start, bus0.o_end, busy0, ew, es, ee, eb); end
            if (ee) begin
                checks++;
                if (pkt_count0 !== 16'(idx / PER + 1))
                    begin errors++; $display("FAIL b2b_count[%0d] got %0d exp %0d", idx, pkt_count0, idx / PER + 1); end
            end
            if (idx == 3 * PER - 1) bus0.req_valid = 1'b0;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (bus0.o_data !== 32'h0 || busy0 !== 1'b0 || pkt_count0 !== 16'd3)
            begin errors++; $display("FAIL b2b_stop got %h busy=%b cnt=%0d exp 0 0 3", bus0.o_data, busy0, pkt_count0); end
    endtask

    task automatic test_reset_mid_pay();
        int cyc, nexp;
        @(negedge clk);
        bus.req_da = 32'h5A5A0001; bus.req_sa = 32'h5A5A0002; bus.req_len = 8'd10; bus.req_seed = 32'h700;
        bus.req_valid = 1'b1;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_data !== 32'h701 || busy !== 1'b1)
            begin errors++; $display("FAIL rst_pre got %h busy=%b exp 00000701 1", bus.o_data, busy); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.o_data !== 32'h0 || bus.o_start !== 1'b0 || bus.o_end !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0 || bus.req_ready !== 1'b0)
            begin errors++; $display("FAIL rst_async got %h s=%b e=%b busy=%b cnt=%0d ready=%b exp all 0", bus.o_data, bus.o_start, bus.o_end, busy, pkt_count, bus.req_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_end !== 1'b0 || bus.o_data !== 32'h0)
                begin errors++; $display("FAIL rst_hold[%0d] got %h e=%b exp 0 0", i, bus.o_data, bus.o_end); end
        end
        rstn = 1'b1;
        send_pkt(32'h600D0001, 32'h600D0002, 8'd2, 32'h42);
        nexp = 2 + 2 + CHKW;
        checks++;
        if (got_to || got_n != nexp)
            begin errors++; $display("FAIL rst_after_len got %0d timeout=%0b exp %0d", got_n, got_to, nexp); end
        for (int k = 0; k < got_n && k < nexp; k++) begin
            checks++;
            if (got_data[k] !== exp_word(k, 32'h600D0001, 32'h600D0002, 32'h42, 2) || got_s[k] !== (k == 0) || got_e[k] !== (k == nexp - 1))
                begin errors++; $display("FAIL rst_after_word[%0d] got %h s=%b e=%b exp %h", k, got_data[k], got_s[k], got_e[k], exp_word(k, 32'h600D0001, 32'h600D0002, 32'h42, 2)); end
        end
        checks++;
        if (pkt_count !== 16'd1)
            begin errors++; $display("FAIL rst_after_count got %0d exp 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_clamp();
        test_back_to_back();
        test_reset_mid_pay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
